stepper_pulse_gen: RTL and testbench

Stepper motion core that sits directly downstream of the MY_IP_STEPPER AXI4-Lite register slave. It latches a move command (direction, step count, half-period) from the register file. It then generates a STEP/DIR pulse train for an external stepper driver with a guaranteed direction-setup delay, and returns busy/done/progress status for register readback.

---
 rtl/stepper_pulse_gen.sv | 152 +++++++++++++++
 tb/tb_stepper_pulse_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/stepper_pulse_gen.sv
// stepper_pulse_gen: latches a move command, then drives a STEP/DIR pulse
// train with a fixed direction-setup delay ahead of the first STEP edge.
// Reports busy, one-cycle done/aborted pulses and a running step count.
module stepper_pulse_gen #(
    parameter int CNT_WIDTH        = 32,
    parameter int DIR_SETUP_CYCLES = 100,
    parameter int MIN_HALF_PERIOD  = 2
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 dir_in,
    input  logic [CNT_WIDTH-1:0] step_count,
    input  logic [CNT_WIDTH-1:0] half_period,
    output logic                 STEP,
    output logic                 DIR,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [CNT_WIDTH-1:0] steps_done
);

    // The phase timer must hold both the setup preload and a half-period.
    localparam int SETUP_W = $clog2(DIR_SETUP_CYCLES + 1);
    localparam int TW      = (CNT_WIDTH > SETUP_W) ? CNT_WIDTH : SETUP_W;

    localparam logic [TW-1:0]        SETUP_LOAD = TW'(DIR_SETUP_CYCLES - 1);
    localparam logic [TW-1:0]        ONE_T      = TW'(1);
    localparam logic [CNT_WIDTH-1:0] ONE_C      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] MIN_H      = CNT_WIDTH'(MIN_HALF_PERIOD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_HIGH  = 2'd2,
        S_LOW   = 2'd3
    } state_t;

    state_t                 state_q;
    logic [TW-1:0]          timer_q;
    logic [CNT_WIDTH-1:0]   n_q;
    logic [CNT_WIDTH-1:0]   h_q;
    logic [CNT_WIDTH-1:0]   steps_q;
    logic                   step_q;
    logic                   dir_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   aborted_q;
    logic [CNT_WIDTH-1:0]   h_clamped_d;
    logic [TW-1:0]          phase_load_d;

    // Clamp the requested half-period and form the per-phase timer preload.
    always_comb begin
        h_clamped_d  = (half_period < MIN_H) ? MIN_H : half_period;
        phase_load_d = TW'(h_q) - ONE_T;
    end

    // Move sequencer: command latch, phase timing, step counting and status.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            n_q       <= '0;
            h_q       <= '0;
            steps_q   <= '0;
            step_q    <= 1'b0;
            dir_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            if ((state_q != S_IDLE) && abort) begin
                // Abort cuts any phase short; a partial HIGH is not counted.
                state_q   <= S_IDLE;
                step_q    <= 1'b0;
                busy_q    <= 1'b0;
                aborted_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // Abort in the same cycle as start wins and drops it.
                        if (start && !abort) begin
                            dir_q   <= dir_in;
                            n_q     <= step_count;
                            h_q     <= h_clamped_d;
                            steps_q <= '0;
                            if (step_count == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q <= S_SETUP;
                                busy_q  <= 1'b1;
                                timer_q <= SETUP_LOAD;
                            end
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_SETUP: begin
                        if (timer_q == '0) begin
                            state_q <= S_HIGH;
                            step_q  <= 1'b1;
                            timer_q <= phase_load_d;
                        end else begin
                            timer_q <= timer_q - ONE_T;
                        end
                    end
                    S_HIGH: begin
                        if (timer_q == '0) begin
                            state_q <= S_LOW;
                            step_q  <= 1'b0;
                            steps_q <= steps_q + ONE_C;
                            timer_q <= phase_load_d;
                        end else begin
                            timer_q <= timer_q - ONE_T;
                        end
                    end
                    S_LOW: begin
                        if (timer_q == '0) begin
                            if (steps_q < n_q) begin
                                state_q <= S_HIGH;
                                step_q  <= 1'b1;
                                timer_q <= phase_load_d;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            timer_q <= timer_q - ONE_T;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        step_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign STEP       = step_q;
    assign DIR        = dir_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign steps_done = steps_q;

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Bench for stepper_pulse_gen: expected outputs for every cycle of a move
// are computed from the cycle-numbering rules (setup length, 2H period,
// step index arithmetic), not from a copy of the sequencer.
module tb_stepper_pulse_gen;

    localparam int W    = 8;
    localparam int D    = 4;
    localparam int MINH = 2;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic         start;
    logic         abort;
    logic         dir_in;
    logic [W-1:0] step_count;
    logic [W-1:0] half_period;
    logic         STEP;
    logic         DIR;
    logic         busy;
    logic         done;
    logic         aborted;
    logic [W-1:0] steps_done;

    int   errors = 0;
    int   checks = 0;
    logic m_dir;
    int   m_sd;

    stepper_pulse_gen #(
        .CNT_WIDTH        (W),
        .DIR_SETUP_CYCLES (D),
        .MIN_HALF_PERIOD  (MINH)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .start       (start),
        .abort       (abort),
        .dir_in      (dir_in),
        .step_count  (step_count),
        .half_period (half_period),
        .STEP        (STEP),
        .DIR         (DIR),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .steps_done  (steps_done)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk_all(input string tag, input int e_step, input int e_busy,
                           input int e_done, input int e_abt, input int e_sd);
        chk({tag, "_step"}, 32'(STEP), e_step);
        chk({tag, "_dir"}, 32'(DIR), 32'(m_dir));
        chk({tag, "_busy"}, 32'(busy), e_busy);
        chk({tag, "_done"}, 32'(done), e_done);
        chk({tag, "_aborted"}, 32'(aborted), e_abt);
        chk({tag, "_steps"}, 32'(steps_done), e_sd);
    endtask

    task automatic chk_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            chk_all(tag, 0, 0, 0, 0, m_sd);
        end
    endtask

    // Starts a move in the current cycle and checks every cycle until the
    // done cycle (left as the current cycle) or the cycle after an abort.
    task automatic do_move(input string tag, input logic d, input int n, input int hp,
                           input int abort_rel, input int mid_rel);
        int h;
        int total;
        int e_sd;
        int e_step;
        h          = (hp < MINH) ? MINH : hp;
        total      = D + 2 * n * h;
        dir_in     = d;
        step_count = W'(n);
        half_period = W'(hp);
        start      = 1'b1;
        abort      = 1'b0;
        m_dir      = d;
        if (n == 0) begin
            tick();
            start = 1'b0;
            m_sd  = 0;
            chk_all({tag, "_zero"}, 0, 0, 1, 0, 0);
            return;
        end
        for (int rel = 1; rel <= total + 1; rel++) begin
            tick();
            if (abort_rel > 0 && rel == abort_rel + 1) begin
                start = 1'b0;
                abort = 1'b0;
                chk_all({tag, "_abort"}, 0, 0, 0, 1, m_sd);
                return;
            end
            e_sd = (rel <= D) ? 0 : (rel - D - 1 + h) / (2 * h);
            if (e_sd > n) e_sd = n;
            e_step = (rel > D && rel <= total && ((rel - D - 1) % (2 * h)) < h) ? 1 : 0;
            chk_all(tag, e_step, (rel <= total) ? 1 : 0, (rel == total + 1) ? 1 : 0, 0, e_sd);
            m_sd = e_sd;
            start = (rel == mid_rel);
            if (rel == mid_rel) begin
                dir_in      = ~d;
                step_count  = W'($urandom_range(1, 9));
                half_period = W'($urandom_range(0, 6));
            end
            abort = (rel == abort_rel);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int n;
        int hp;
        int h;
        int ab;
        ARESET      = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        dir_in      = 1'b0;
        step_count  = '0;
        half_period = '0;
        m_dir       = 1'b0;
        m_sd        = 0;
        #3;
        chk_all("reset", 0, 0, 0, 0, 0);
        tick();
        ARESET = 1'b0;
        chk_idle("post_reset", 2);

        do_move("nominal", 1'b1, 2, 3, 0, 0);
        chk_idle("after_nominal", 2);
        do_move("clamp0", 1'b0, 3, 0, 0, 0);
        do_move("clamp1", 1'b1, 2, 1, 0, 0);
        chk_idle("after_clamp", 2);
        do_move("zero", 1'b0, 0, 4, 0, 0);
        chk_idle("after_zero", 3);

        do_move("abort", 1'b1, 10, 3, D + 20, 0);
        chk_idle("after_abort", 3);

        do_move("ignore_start", 1'b1, 3, 2, 0, D + 3);
        chk_idle("after_ignore", 1);

        start      = 1'b1;
        abort      = 1'b1;
        dir_in     = ~m_dir;
        step_count = W'(5);
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk_all("start_abort_idle", 0, 0, 0, 0, m_sd);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_all("abort_idle", 0, 0, 0, 0, m_sd);
        chk_idle("after_abort_idle", 2);

        do_move("b2b_first", 1'b0, 2, 2, 0, 0);
        do_move("b2b_second", 1'b1, 1, 3, 0, 0);
        chk_idle("after_b2b", 2);

        do_move("max_count", 1'b1, (1 << W) - 1, 2, 0, 0);
        chk_idle("after_max", 1);

        for (int i = 0; i < 12; i++) begin
            n  = $urandom_range(0, 6);
            hp = $urandom_range(0, 5);
            h  = (hp < MINH) ? MINH : hp;
            ab = ($urandom_range(0, 2) == 0 && n > 0) ? $urandom_range(1, D + 2 * n * h) : 0;
            do_move("random", 1'($urandom_range(0, 1)), n, hp, ab, 0);
            if ($urandom_range(0, 1) == 1) chk_idle("random_gap", $urandom_range(1, 3));
        end

        // Reset mid-move while STEP is high and one step has been counted.
        dir_in      = 1'b1;
        step_count  = W'(5);
        half_period = W'(3);
        start       = 1'b1;
        tick();
        start = 1'b0;
        repeat (D + 8) tick();
        chk("pre_reset_busy", 32'(busy), 1);
        #2;
        ARESET = 1'b1;
        #1;
        m_dir = 1'b0;
        m_sd  = 0;
        chk_all("mid_reset", 0, 0, 0, 0, 0);
        tick();
        ARESET = 1'b0;
        chk_idle("after_mid_reset", 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
